// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    // addi x0, x0, 0 -- presented to the decoder whenever nothing is queued.
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    // One prefetch-queue slot: the fetched word together with its address.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} entries. Flush empties it in
// one edge; push while full is accepted only together with a pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // Pointer and occupancy update; flush overrides push and pop.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch is inferred.
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the occupancy count decides which slots are meaningful.
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    // Occupancy must never exceed the configured depth.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_bound: assert (count_q <= DEPTH_C);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads IMEM combinationally, buffers
// fetched words in a prefetch queue and hands them to the decoder.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int                QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               misalign_err
);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               misalign_q, misalign_d;

    logic               running;
    logic               take_redirect;
    logic               push, pop;
    logic               q_full, q_empty;
    fetch_entry_t       wentry, head;

    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (take_redirect),
        .wdata (wentry),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty)
    );

    assign imem_addr    = pc_q;
    assign misalign_err = misalign_q;
    assign wentry       = '{pc: pc_q, instr: imem_instr};
    assign out_instr    = q_empty ? NOP_INSTR : head.instr;
    assign out_pc       = q_empty ? '0 : head.pc;

    // Handshake, queue control, PC advance and FSM next-state.
    always_comb begin
        running       = (state_q == RUN);
        take_redirect = running & redirect_valid;
        out_valid     = ~q_empty & ~redirect_valid & running;
        pop           = out_valid & out_ready;
        // A full queue still accepts a fetch when the head leaves this cycle.
        push          = running & ~redirect_valid & (~q_full | pop);

        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        unique case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    if (redirect_pc[1:0] != 2'b00) begin
                        // Misaligned target: stop fetching, keep the PC for debug.
                        state_d    = HALT;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (push) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            HALT: begin
                // Frozen until reset; redirects are ignored.
            end
        endcase
    end

    // PC, FSM state and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            state_q    <= RUN;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            state_q    <= state_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: two fixed words, address-derived elsewhere.
    function automatic logic [31:0] instr_at(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00A0_0113;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign imem_instr = instr_at(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc   = '0;
    bit          mhalt = 1'b0;
    bit          merr  = 1'b0;
    bit          mok   = 1'b0;

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit offered;
        if (rst) begin
            mq.delete();
            mpc   = RESET_PC;
            mhalt = 1'b0;
            merr  = 1'b0;
            mok   = 1'b1;
            return;
        end
        if (!mok || mhalt) return;
        if (redirect_valid) begin
            mq.delete();
            if (redirect_pc[1:0] == 2'b00) begin
                mpc = redirect_pc;
            end else begin
                mhalt = 1'b1;
                merr  = 1'b1;
            end
            return;
        end
        offered = (mq.size() != 0);
        if (offered && out_ready) void'(mq.pop_front());
        if (mq.size() < QDEPTH) begin
            mq.push_back('{pc: mpc, instr: instr_at(mpc)});
            mpc = mpc + 32'd4;
        end
    endtask

    // Compare process: check outputs mid-cycle, then step the model at the edge.
    initial begin
        logic exp_valid;
        forever begin
            @(negedge clk);
            #2;
            if (mok) begin
                exp_valid = (mq.size() != 0) && !redirect_valid && !mhalt;
                check("model_out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
                check("model_out_pc", out_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
                check("model_out_instr", out_instr, (mq.size() != 0) ? mq[0].instr : NOP);
                check("model_imem_addr", imem_addr, mpc);
                check("model_misalign", {31'b0, misalign_err}, {31'b0, merr});
            end
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #3;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;

        // 1: reset then stream at full rate.
        do_reset();
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("t1_c0_valid", {31'b0, out_valid}, 32'd0);
        check("t1_c0_addr", imem_addr, 32'h0);
        check("t1_c0_instr", out_instr, NOP);
        check("t1_c0_pc", out_pc, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("t1_c1_valid", {31'b0, out_valid}, 32'd1);
        check("t1_c1_pc", out_pc, 32'h0);
        check("t1_c1_instr", out_instr, 32'h0050_0093);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("t1_c2_pc", out_pc, 32'h4);
        check("t1_c2_instr", out_instr, 32'h00A0_0113);

        // 2: backpressure saturates the queue, then drains in order.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check("t2_hold_addr", imem_addr, 32'h8);
        check("t2_hold_pc", out_pc, 32'h0);
        check("t2_hold_valid", {31'b0, out_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1);
            check("t2_drain_pc", out_pc, 32'(i * 4));
        end

        // 3: redirect while queue holds 8 and C.
        do_reset();
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b1, 32'h40, 1'b1);
        check("t3_redir_valid", {31'b0, out_valid}, 32'd0);
        check("t3_redir_head", out_pc, 32'h8);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("t3_gap_valid", {31'b0, out_valid}, 32'd0);
        check("t3_gap_addr", imem_addr, 32'h40);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("t3_new_valid", {31'b0, out_valid}, 32'd1);
        check("t3_new_pc", out_pc, 32'h40);
        check("t3_new_instr", out_instr, 32'h5A5A_0040);

        // 4: misaligned redirect halts; later redirect ignored; reset clears.
        cyc(1'b0, 1'b1, 32'h42, 1'b1);
        check("t4_redir_valid", {31'b0, out_valid}, 32'd0);
        cyc(1'b0, 1'b1, 32'h80, 1'b1);
        check("t4_err", {31'b0, misalign_err}, 32'd1);
        check("t4_halt_addr", imem_addr, 32'h48);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("t4_ignored_addr", imem_addr, 32'h48);
        check("t4_halt_valid", {31'b0, out_valid}, 32'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("t4_rst_err", {31'b0, misalign_err}, 32'd0);
        check("t4_rst_addr", imem_addr, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("t4_rst_out_pc", out_pc, 32'h0);
        check("t4_rst_out_valid", {31'b0, out_valid}, 32'd1);

        // 5: PC wraps through 2^32.
        cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("t5_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("t5_pc0", out_pc, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("t5_pc1", out_pc, 32'h0000_0000);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("t5_pc2", out_pc, 32'h0000_0004);

        // Back-to-back redirects: the last one wins.
        cyc(1'b0, 1'b1, 32'h200, 1'b1);
        cyc(1'b0, 1'b1, 32'h300, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("b2b_addr", imem_addr, 32'h300);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("b2b_pc", out_pc, 32'h300);

        // 6: reset beats a simultaneous pop and misaligned redirect while full.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 32'h102, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check("t6_addr", imem_addr, RESET_PC);
        check("t6_valid", {31'b0, out_valid}, 32'd0);
        check("t6_err", {31'b0, misalign_err}, 32'd0);
        check("t6_out_pc", out_pc, 32'h0);
        check("t6_out_instr", out_instr, NOP);

        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
